// File: rtl/pwm_log_pkg.sv
// Shared encodings and record field layout for the PWM edge logger.
// Record layout, MSB to LSB: {type[1:0], ts[TS_W-1:0], mask[NCH-1:0], level[NCH-1:0]}.
package pwm_log_pkg;

    typedef enum logic [1:0] {
        REC_START = 2'b00,
        REC_EDGE  = 2'b01,
        REC_WRAP  = 2'b10,
        REC_STOP  = 2'b11
    } rec_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned TYPE_W = 2;

    function automatic int unsigned mask_lsb(int unsigned nch);
        return nch;
    endfunction

    function automatic int unsigned ts_lsb(int unsigned nch);
        return 2 * nch;
    endfunction

    function automatic int unsigned type_lsb(int unsigned nch, int unsigned tsw);
        return 2 * nch + tsw;
    endfunction

    function automatic int unsigned rec_w(int unsigned nch, int unsigned tsw);
        return 2 * nch + tsw + TYPE_W;
    endfunction

endpackage

// File: rtl/pwm_edge_logger_if.sv
// Record stream from the logger FIFO head to its consumer (valid/ready).
interface pwm_edge_logger_if #(
    parameter int unsigned W = 14
);
    logic         rec_valid;
    logic         rec_ready;
    logic [W-1:0] rec_data;

    modport master (output rec_valid, output rec_data, input rec_ready);
    modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/pwm_log_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is taken only
// when a pop frees the head slot in the same cycle.
module pwm_log_fifo #(
    parameter int unsigned W     = 14,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               head_c,
    output logic                       empty_c,
    output logic                       full_c,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign empty_c = (count == CW'(0));
    assign full_c  = (count == CW'(DEPTH));
    assign head_c  = mem[rd_ptr];
    assign pop_ok  = pop & ~empty_c;
    assign push_ok = push & (~full_c | pop_ok);

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/pwm_edge_logger.sv
// Timestamped PWM edge logger: START/EDGE/STOP records per capture session.
// Define PWM_LOG_WRAP_MARK_EN to also log a WRAP record when the timestamp rolls over.
module pwm_edge_logger
    import pwm_log_pkg::*;
#(
    parameter int unsigned NCH   = 2,
    parameter int unsigned TS_W  = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NCH-1:0]         pwm_in,
    input  logic                   clr,
    pwm_edge_logger_if.master      rec,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   ovf
);
    localparam int unsigned RW       = rec_w(NCH, TS_W);
    localparam int unsigned MASK_LSB = mask_lsb(NCH);
    localparam int unsigned TS_LSB   = ts_lsb(NCH);
    localparam int unsigned TYPE_LSB = type_lsb(NCH, TS_W);

    logic            en_s1, en_s2;
    logic [NCH-1:0]  pwm_s1, pwm_s2;
    state_e          state_q, state_d;
    logic [TS_W-1:0] ts_q, ts_d;

    logic            push;
    rec_type_e       rtype;
    logic [TS_W-1:0] rts;
    logic [NCH-1:0]  rmask;
    logic [RW-1:0]   din;
    logic            pop;
    logic            empty;
    logic            full;
    logic            drop;

    // Two-stage input history; all detection compares s1 against s2.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_s1  <= 1'b0;
            en_s2  <= 1'b0;
            pwm_s1 <= '0;
            pwm_s2 <= '0;
        end else begin
            en_s1  <= en;
            en_s2  <= en_s1;
            pwm_s1 <= pwm_in;
            pwm_s2 <= pwm_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
        end
    end

    // The start cycle is timestamp 0, so the first RUN cycle is already 1.
    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        push    = 1'b0;
        rtype   = REC_EDGE;
        rts     = ts_q;
        rmask   = '0;
        case (state_q)
            ST_IDLE: begin
                if (en_s1 && !en_s2) begin
                    state_d = ST_RUN;
                    push    = 1'b1;
                    rtype   = REC_START;
                    rts     = '0;
                    ts_d    = TS_W'(1);
                end
            end
            ST_RUN: begin
                ts_d = ts_q + TS_W'(1);
                if (!en_s1 && en_s2) begin
                    state_d = ST_IDLE;
                    push    = 1'b1;
                    rtype   = REC_STOP;
                end else if (pwm_s1 != pwm_s2) begin
                    push  = 1'b1;
                    rtype = REC_EDGE;
                    rmask = pwm_s1 ^ pwm_s2;
                end
`ifdef PWM_LOG_WRAP_MARK_EN
                else if (ts_q == '0) begin
                    push  = 1'b1;
                    rtype = REC_WRAP;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        din                        = '0;
        din[0 +: NCH]              = pwm_s1;
        din[MASK_LSB +: NCH]       = rmask;
        din[TS_LSB +: TS_W]        = rts;
        din[TYPE_LSB +: TYPE_W]    = rtype;
    end

    assign pop           = rec.rec_valid & rec.rec_ready;
    assign rec.rec_valid = ~empty;
    assign drop          = push & full & ~pop;

    pwm_log_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .din     (din),
        .pop     (pop),
        .head_c  (rec.rec_data),
        .empty_c (empty),
        .full_c  (full),
        .count   (fifo_count)
    );

    // A drop outranks a simultaneous clear so no loss goes unreported.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_edge_logger.sv
// Scoreboard bench for pwm_edge_logger: expected records are queued as stimulus
// is driven (timestamps derived from the bench cycle count) and checked on pop.
module tb_pwm_edge_logger;
    import pwm_log_pkg::*;

    localparam int unsigned NCH   = 2;
    localparam int unsigned TS_W  = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RW    = TS_W + 2 * NCH + 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic                   clr;
    logic [NCH-1:0]         pwm;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   ovf;

    pwm_edge_logger_if #(.W(RW)) rif ();

    pwm_edge_logger #(
        .NCH   (NCH),
        .TS_W  (TS_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pwm_in     (pwm),
        .clr        (clr),
        .rec        (rif),
        .fifo_count (fifo_count),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    int            checks      = 0;
    int            fails       = 0;
    int            cyc         = 0;
    int            d_en        = 0;
    int            model_count = 0;
    bit            in_session  = 1'b0;
    bit            pop_same    = 1'b0;
    bit            exp_ovf     = 1'b0;
    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [RW-1:0] mkrec(input rec_type_e t, input logic [TS_W-1:0] ts,
                                            input logic [NCH-1:0] m, input logic [NCH-1:0] l);
        return {2'(t), ts, m, l};
    endfunction

    // Queue an expected record unless the model FIFO is full (then it is a drop).
    task automatic exp_rec(input rec_type_e t, input logic [TS_W-1:0] ts,
                           input logic [NCH-1:0] m, input logic [NCH-1:0] l);
        if (model_count < int'(DEPTH) || pop_same) begin
            exp_q.push_back(mkrec(t, ts, m, l));
            model_count++;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    // Head pops happen at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && rif.rec_valid && rif.rec_ready) begin
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                model_count--;
            end else begin
                mon_exp = '1;
            end
            check("rec", 32'(rif.rec_data), 32'(mon_exp));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Inputs driven now are captured at drive cycle d = cyc + 1.
    task automatic cyc_end(input bit had_rec);
`ifdef PWM_LOG_WRAP_MARK_EN
        if (in_session && !had_rec && (cyc + 1 - d_en) > 0 && ((cyc + 1 - d_en) % 256) == 0)
            exp_rec(REC_WRAP, '0, '0, pwm);
`endif
        tick(1);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_end(1'b0);
    endtask

    task automatic start_session();
        en         = 1'b1;
        d_en       = cyc + 1;
        in_session = 1'b1;
        exp_rec(REC_START, '0, '0, pwm);
        cyc_end(1'b1);
    endtask

    task automatic stop_session();
        exp_rec(REC_STOP, TS_W'(cyc + 1 - d_en), '0, pwm);
        en = 1'b0;
        cyc_end(1'b1);
        in_session = 1'b0;
    endtask

    task automatic set_pwm(input logic [NCH-1:0] v);
        bit had;
        had = in_session && (v != pwm);
        if (had) exp_rec(REC_EDGE, TS_W'(cyc + 1 - d_en), pwm ^ v, v);
        pwm = v;
        cyc_end(had);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pwm = '0; clr = 1'b0; rif.rec_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_valid", 32'(rif.rec_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf",   32'(ovf), 32'd0);
        check("rst_data",  32'(rif.rec_data), 32'd0);

        // START latency and content, then a two-channel edge at ts=100 and STOP.
        pwm = 2'b01;
        start_session();
        check("start_lat_early", 32'(rif.rec_valid), 32'd0);
        idle(1);
        check("start_lat_2cyc", 32'(rif.rec_valid), 32'd1);
        check("start_count", 32'(fifo_count), 32'd1);
        rif.rec_ready = 1'b1;
        while (cyc + 1 - d_en < 100) idle(1);
        set_pwm(2'b10);
        idle(5);
        set_pwm(2'b11);
        idle(3);
        stop_session();
        idle(2);
        set_pwm(2'b00);
        set_pwm(2'b01);
        idle(6);
        check("post_stop_count", 32'(fifo_count), 32'd0);
        check("post_stop_q", 32'(exp_q.size()), 32'd0);

        // Overflow: START plus six edges into a 4-deep FIFO with no consumer.
        rif.rec_ready = 1'b0;
        exp_ovf = 1'b0;
        start_session();
        idle(1);
        for (int i = 0; i < 6; i++) begin
            set_pwm(pwm ^ 2'b01);
            idle(1);
        end
        idle(3);
        check("ovf_count", 32'(fifo_count), 32'(DEPTH));
        check("ovf_set", 32'(ovf), 32'(exp_ovf));
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        idle(1);
        check("ovf_clr", 32'(ovf), 32'd0);

        // Full FIFO: push and pop in the same cycle are both taken.
        pop_same = 1'b1;
        set_pwm(pwm ^ 2'b10);
        pop_same = 1'b0;
        rif.rec_ready = 1'b1;
        idle(1);
        rif.rec_ready = 1'b0;
        idle(1);
        check("swap_count", 32'(fifo_count), 32'(DEPTH));
        check("swap_ovf", 32'(ovf), 32'd0);

        // Drop and clear in the same cycle leave ovf set.
        set_pwm(pwm ^ 2'b01);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        idle(1);
        check("clr_vs_drop_ovf", 32'(ovf), 32'd1);
        rif.rec_ready = 1'b1;
        idle(8);
        check("drain_count", 32'(fifo_count), 32'd0);
        stop_session();
        idle(4);

        // Reset mid-session discards queued records; en still high restarts.
        rif.rec_ready = 1'b0;
        start_session();
        idle(1);
        set_pwm(pwm ^ 2'b11);
        idle(3);
        in_session = 1'b0;
        rst = 1'b1;
        idle(2);
        check("rst_run_valid", 32'(rif.rec_valid), 32'd0);
        check("rst_run_count", 32'(fifo_count), 32'd0);
        check("rst_run_ovf", 32'(ovf), 32'd0);
        exp_q.delete();
        model_count = 0;
        rst = 1'b0;
        d_en = cyc + 1;
        in_session = 1'b1;
        exp_rec(REC_START, '0, '0, pwm);
        cyc_end(1'b1);
        idle(1);
        check("restart_count", 32'(fifo_count), 32'd1);
        rif.rec_ready = 1'b1;
        idle(3);
        stop_session();
        idle(4);

        // Long session with no edges: WRAP marks only when enabled.
        start_session();
        idle(300);
        set_pwm(pwm ^ 2'b10);
        idle(2);
        stop_session();
        idle(4);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick(1);
        check("final_q", 32'(exp_q.size()), 32'd0);
        check("final_count", 32'(fifo_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/pwm_edge_logger.md
PWM_EDGE_LOGGER -- requirements
Module: pwm_edge_logger

Interface
REQ-001 SHALL have parameter NCH, default 2, number of PWM channels monitored (1..8).
REQ-002 SHALL have parameter TS_W, default 24, timestamp width in bits (8..32).
REQ-003 SHALL have parameter DEPTH, default 16, FIFO depth in records, power of two (4..256).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port en  input  1  capture enable; rising starts a session, falling ends it.
REQ-007 SHALL have port pwm_in  input  NCH  PWM pins, synchronous to clk.
REQ-008 SHALL have port clr  input  1  one-cycle pulse clearing ovf.
REQ-009 SHALL have port rec_valid  output  1  FIFO head record available.
REQ-010 SHALL have port rec_ready  input  1  consumer accepts the head record when high with rec_valid.
REQ-011 SHALL have port rec_data  output  TS_W+2*NCH+2  record {type[1:0], ts[TS_W-1:0], mask[NCH-1:0], level[NCH-1:0]}.
REQ-012 SHALL have port fifo_count  output  $clog2(DEPTH)+1  records held.
REQ-013 SHALL have port ovf  output  1  sticky flag: a record was dropped.

Function
REQ-014 SHALL register pwm_in and en once per cycle (stage s1); all detection SHALL compare s1 with its previous value (s2).
REQ-015 SHALL define record types START=00, EDGE=01, WRAP=10, STOP=11.
REQ-016 SHALL use a two-state FSM: IDLE and RUN; IDLE->RUN on s1.en & ~s2.en; RUN->IDLE on ~s1.en & s2.en.
REQ-017 On IDLE->RUN SHALL clear ts to 0 and push START with ts=0, mask=0, level=s1.pwm.
REQ-018 In RUN, ts SHALL increment by 1 every cycle, wrapping from 2^TS_W-1 to 0.
REQ-019 In RUN, when s1.pwm != s2.pwm SHALL push EDGE with ts=current ts, mask=s1.pwm^s2.pwm, level=s1.pwm; simultaneous channel changes SHALL share one record.
REQ-020 On RUN->IDLE SHALL push STOP with current ts, mask=0, level=s1.pwm; no further records until the next START.
REQ-021 SHALL push at most one record per cycle; priority STOP > EDGE > WRAP.
REQ-022 Record SHALL appear on rec_data/rec_valid the cycle after the push edge (latency 2 cycles from pwm_in change to rec_valid on an empty FIFO).
REQ-023 FIFO SHALL be first-word fall-through; pop occurs on rec_valid & rec_ready; rec_ready while empty SHALL have no effect.
REQ-024 A push while full SHALL be accepted only if a pop occurs in the same cycle; otherwise the record SHALL be dropped and ovf set.
REQ-025 ovf SHALL clear on clr; clr and a drop in the same cycle SHALL leave ovf=1.
REQ-026 fifo_count SHALL never exceed DEPTH; simultaneous push and pop SHALL leave it unchanged.

Reset
REQ-027 On rst SHALL set: FSM=IDLE, ts=0, FIFO empty, rec_valid=0, fifo_count=0, ovf=0, rec_data=0, s1/s2=0.
REQ-028 rst during RUN SHALL discard all queued records and emit no STOP; if en is still high after reset, the 0->1 of s1.en SHALL start a new session.

Configuration
REQ-029 With PWM_LOG_WRAP_MARK_EN defined, SHALL push WRAP (ts=0, mask=0, level=s1.pwm) in the RUN cycle ts wraps to 0 unless a STOP or EDGE is pushed that cycle (that record carries ts=0 instead).
REQ-030 Without PWM_LOG_WRAP_MARK_EN, SHALL never emit WRAP; type 10 SHALL be unused.

Structure
REQ-031 Package pwm_log_pkg SHALL hold the record type encoding, field offset/width functions of NCH and TS_W, and FSM state encoding.
REQ-032 The FIFO SHALL be sub-module pwm_log_fifo (parametrised width/depth, sync, FWFT, full/empty/count).

Verification
REQ-033 NCH=2, TS_W=24: en 0->1, pwm_in=01 -> START, ts=0, mask=00, level=01 appears 2 cycles later.
REQ-034 In RUN, pwm_in 01->10 at ts=100 -> one EDGE, ts=100, mask=11, level=10.
REQ-035 DEPTH=4, rec_ready=0, 6 edges -> fifo_count=4, ovf=1, first four records retained in order; clr -> ovf=0.
REQ-036 TS_W=8, macro defined, no edges for 300 cycles -> WRAP records at ts rollovers 256 cycles apart; macro undefined -> none.
REQ-037 en 1->0 with level 11 -> STOP, mask=00, level=11; later pwm changes produce no records.
REQ-038 Full FIFO, edge push and rec_ready pop same cycle -> record accepted, fifo_count stays 4, ovf stays 0.
